matrix_wb_sequencer: RTL
========================

# matrix_wb_sequencer

Drains a completed matrix-unit result vector into the register file, one 8-bit element per cycle, through the writeback select mux. It sits directly upstream of the writeback mux. It drives the mux's matrix-side inputs (data, destination register, write enable) and the select line. The normal pipeline writeback always has priority: the sequencer stalls itself whenever the pipeline writes in the same cycle, so no pipeline write is ever lost or delayed.

## Interface
Parameters:
- N_ELEM, 4, maximum elements per transfer (result vector holds N_ELEM × 8 bits)
- IDX_W, 3, width of count/index fields (must hold N_ELEM)

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a transfer; sampled only in IDLE
- base_reg  input  3  destination register of element 0
- count  input  IDX_W  number of elements to write (0..N_ELEM; larger values clamp to N_ELEM)
- result_vec  input  8*N_ELEM  matrix results; element i is bits [8i+7:8i]
- pipe_write  input  1  pipeline writeback write enable for the current cycle
- wrtdata1  output  8  element data to the writeback mux (matrix side)
- destreg1  output  3  destination register to the writeback mux
- write1  output  1  write enable to the writeback mux
- sel  output  1  writeback mux select (1 = matrix side)
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse when a transfer completes

## Operation
- State register: IDLE, WRITE, DONE. Registers: vec_q (latched result_vec), base_q, cnt_q, idx_q.
- IDLE, start=1: latch result_vec, base_reg, and the clamped count. Set idx_q=0. Go to WRITE, or to DONE if count==0.
- IDLE, start=0: stay.
- start is ignored in WRITE and DONE. There is no queueing.
- WRITE, pipe_write=0:
  - sel=1, write1=1.
  - wrtdata1 = element idx_q of vec_q.
  - destreg1 = (base_q + idx_q) mod 8. Destination register wraps, e.g. base 6, idx 3 → r1.
  - idx_q increments.
  - After the element with idx_q == cnt_q−1 is written, go to DONE.
- WRITE, pipe_write=1: sel=0, write1=0. idx_q holds and the state holds (yield cycle).
- DONE: done=1 for exactly one cycle, then go to IDLE.
- sel and write1 are combinational: (state==WRITE) & ~pipe_write. They are always equal.
- wrtdata1 and destreg1 show the current element throughout WRITE, including yield cycles. They are 0 in IDLE and DONE.
- No special case for r0. Writes to any register code are issued as-is.
- Reset mid-transfer: the transfer is abandoned. No further writes and no done pulse.

## Timing
- Reset values: state=IDLE, all internal registers 0. wrtdata1=0, destreg1=0, write1=0, sel=0, busy=0, done=0.
- start at edge T is accepted. busy=1 from cycle T+1.
- With no conflicts, the first write occurs in cycle T+1. Element k is written in cycle T+1+k.
- count=n with no conflicts: writes in T+1..T+n, done in T+n+1, back in IDLE (busy=0) at T+n+2.
- Each pipe_write=1 cycle during WRITE adds exactly one cycle of latency.
- count=0: done at T+1, no writes.
- Earliest next start: the cycle busy=0 after done.
- result_vec, base_reg and count need to be valid only in the start cycle. Later changes have no effect.

## Test plan
- Reset, then count=4, base=2, vec={0x44,0x33,0x22,0x11}, no pipe_write → writes r2=0x11, r3=0x22, r4=0x33, r5=0x44 on consecutive cycles; done one cycle after the last write.
- count=3, base=6, pipe_write=1 in the second WRITE cycle → writes r6, yield (sel=0, write1=0, destreg1=r7 held), then r7, r0; done one cycle later than the no-conflict case.
- count=0 → no write1 pulses, done at T+1, busy high for exactly one cycle.
- count=7 with N_ELEM=4 → clamped: exactly 4 writes.
- start pulses during WRITE and during DONE are ignored, with the original vector unaffected. A start on the first IDLE cycle is accepted.
- rst_n asserted after 2 of 4 writes → outputs zero immediately (asynchronous). After release: no further writes, no done pulse, IDLE.

Source files
------------

// File: rtl/matrix_wb_sequencer.sv
// Drains a latched matrix result vector into the register file, one 8-bit element per cycle, through the writeback mux.
// Latency: first write in the cycle after start, one element per cycle, done pulse one cycle after the last write.
// Backpressure: a pipeline write (pipe_write) always wins; the sequencer yields that cycle and holds its element.
module matrix_wb_sequencer #(
    parameter int N_ELEM = 4,
    parameter int IDX_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            base_reg,
    input  logic [IDX_W-1:0]      count,
    input  logic [8*N_ELEM-1:0]   result_vec,
    input  logic                  pipe_write,
    output logic [7:0]            wrtdata1,
    output logic [2:0]            destreg1,
    output logic                  write1,
    output logic                  sel,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] N_MAX = IDX_W'(N_ELEM);

    state_t                state_q, state_d;
    logic [8*N_ELEM-1:0]   vec_q, vec_d;
    logic [2:0]            base_q, base_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      count_clamped;
    logic [7:0]            elem;
    logic                  in_write;

    assign count_clamped = (count > N_MAX) ? N_MAX : count;

    always_comb begin
        elem = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (idx_q == IDX_W'(i)) begin
                elem = vec_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d   = result_vec;
                    base_d  = base_reg;
                    cnt_d   = count_clamped;
                    idx_d   = '0;
                    state_d = (count_clamped == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                // A pipeline write in this cycle means the mux is not ours; hold everything.
                if (!pipe_write) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == cnt_q - IDX_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            base_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    assign in_write = (state_q == WRITE);
    assign write1   = in_write & ~pipe_write;
    assign sel      = write1;
    // Destination wraps modulo 8 through the 3-bit add.
    assign destreg1 = in_write ? (base_q + 3'(idx_q)) : 3'd0;
    assign wrtdata1 = in_write ? elem : 8'd0;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

endmodule
